game_sequencer: RTL and testbench
=================================

# game_sequencer

Central per-tick scheduler for the snake game. It sits between the VSYNC-driven frame timing and the snake/apple datapath. Each game tick runs as a fixed sequence: wait N frames, wait for the apple to be placed, pulse the snake tick, then wait for the snake to finish. It also owns pause, speed, outcome latching (failure/success) and a watchdog on the snake's tick handshake.

## Interface
Parameters:
- FRAMES_INIT, 8, frames per tick after reset/restart (range FRAMES_MIN..FRAMES_MAX)
- FRAMES_MIN, 2, fastest allowed period
- FRAMES_MAX, 15, slowest allowed period (≤15, fits 4 bits)
- DONE_TIMEOUT, 255, max cycles in WAIT_DONE before watchdog fires (8-bit counter)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  reset; asynchronous and active-high
- i_restart  in  1  synchronous game restart, same effect as rst
- i_start  in  1  level from control block; first user direction seen
- i_pause  in  1  level; pause request
- i_vsync  in  1  one-cycle pulse per frame
- i_speed_up  in  1  one-cycle pulse; period −1
- i_speed_down  in  1  one-cycle pulse; period +1
- i_apple_ready  in  1  apple placed and valid
- i_tick_done  in  1  one-cycle pulse from snake when tick processing is finished
- i_snake_failure  in  1  collision detected
- i_snake_success  in  1  board full
- o_snake_tick  out  1  one-cycle pulse; advance snake
- o_state  out  3  current state encoding
- o_running  out  1  state is WAIT_FRAME, WAIT_APPLE, TICK or WAIT_DONE
- o_period  out  4  current frames-per-tick
- o_failure  out  1  sticky failure
- o_success  out  1  sticky success
- o_timeout  out  1  sticky watchdog flag

## Operation
State encodings:
- IDLE=0, WAIT_FRAME=1, WAIT_APPLE=2, TICK=3, WAIT_DONE=4, PAUSED=5, FAILED=6, WON=7

Transitions (evaluated in priority order):
- rst or i_restart → IDLE. Clears frame count, watchdog, o_failure, o_success and o_timeout. o_period ← FRAMES_INIT.
- Any state except IDLE, FAILED and WON, with i_snake_failure=1 → FAILED and o_failure←1.
- Same states, else with i_snake_success=1 → WON and o_success←1.
- Failure wins if both assert in the same cycle.
- FAILED and WON are terminal; only restart/rst exits them.
- IDLE → WAIT_FRAME when i_start=1. Frame count ← 0.
- WAIT_FRAME:
  - If i_pause=1 → PAUSED; frame count is held.
  - Else on i_vsync: if count == o_period−1 → WAIT_APPLE, otherwise count+1.
- PAUSED → WAIT_FRAME when i_pause=0. Count resumes from the held value. i_vsync is ignored while paused.
- WAIT_APPLE → TICK when i_apple_ready=1. It waits indefinitely otherwise, and i_pause is ignored here.
- TICK lasts exactly one cycle, then → WAIT_DONE with watchdog ← 0.
- WAIT_DONE:
  - On i_tick_done → WAIT_FRAME, count ← 0. A pending pause takes effect in the next cycle via the WAIT_FRAME rule.
  - Otherwise watchdog+1. When watchdog == DONE_TIMEOUT: o_timeout←1, → WAIT_FRAME, count ← 0.
- Speed control:
  - i_speed_up decrements o_period, saturating at FRAMES_MIN.
  - i_speed_down increments o_period, saturating at FRAMES_MAX.
  - Both high in the same cycle: no change.
  - Speed pulses are accepted in every state. The new period is used at the next vsync compare.
  - If count ≥ new period−1 when a vsync arrives, the tick fires on that vsync (compare with ≥).

## Timing
- Reset values: o_state=0, o_snake_tick=0, o_running=0, o_period=FRAMES_INIT, o_failure=0, o_success=0, o_timeout=0.
- All outputs are registered except o_running, which is a combinational decode of the state register.
- o_snake_tick is high exactly during the cycle o_state=TICK.
- Latency from the qualifying vsync to o_snake_tick:
  - 2 cycles if i_apple_ready is already high (WAIT_APPLE 1 cycle, then TICK).
  - Otherwise 1 cycle after i_apple_ready is first seen high in WAIT_APPLE.
- i_tick_done is ignored in every state except WAIT_DONE. A done pulse coincident with TICK is lost, and the watchdog covers that case.
- i_vsync is ignored outside WAIT_FRAME; no vsync credits accumulate.
- A restart in mid-sequence, including in TICK, forces IDLE next cycle. o_snake_tick drops in that same cycle.
- Async rst deasserts synchronously externally; the block needs no internal synchronizer.

## Test plan
- Reset, hold i_start=1, i_apple_ready=1, snake returns i_tick_done 3 cycles after each tick, FRAMES_INIT=8 → first o_snake_tick 2 cycles after the 8th vsync; exactly one pulse per 8 vsyncs thereafter; o_running=1.
- In WAIT_FRAME, at count=3, raise i_pause for 20 vsyncs then drop it → o_state=5 during the pause, no ticks; the tick fires on the 5th vsync after resume.
- Eight i_speed_up pulses → o_period saturates at 2. Eighteen i_speed_down pulses → o_period saturates at 15. Simultaneous up+down → unchanged.
- Hold i_apple_ready=0 for 100 cycles after the 8th vsync → o_state=2 and no tick. Raise it → o_snake_tick 1 cycle later.
- Never return i_tick_done → o_timeout=1 after 255 cycles in WAIT_DONE; state → WAIT_FRAME; the next tick sequence proceeds normally.
- Assert i_snake_failure and i_snake_success in the same cycle in WAIT_DONE → o_state=6, o_failure=1, o_success=0, no further ticks on vsync. i_restart → o_state=0, flags cleared, o_period=8.

Source files
------------

// File: rtl/game_sequencer_if.sv
// Handshake bundle between the snake game sequencer and its surroundings.
// The slave side is the sequencer itself; the master side is whatever drives
// frame timing, user controls and the snake/apple datapath.
interface game_sequencer_if;
  logic       i_restart;
  logic       i_start;
  logic       i_pause;
  logic       i_vsync;
  logic       i_speed_up;
  logic       i_speed_down;
  logic       i_apple_ready;
  logic       i_tick_done;
  logic       i_snake_failure;
  logic       i_snake_success;
  logic       o_snake_tick;
  logic [2:0] o_state;
  logic       o_running;
  logic [3:0] o_period;
  logic       o_failure;
  logic       o_success;
  logic       o_timeout;

  modport master (
    output i_restart, i_start, i_pause, i_vsync, i_speed_up, i_speed_down,
           i_apple_ready, i_tick_done, i_snake_failure, i_snake_success,
    input  o_snake_tick, o_state, o_running, o_period, o_failure, o_success,
           o_timeout
  );

  modport slave (
    input  i_restart, i_start, i_pause, i_vsync, i_speed_up, i_speed_down,
           i_apple_ready, i_tick_done, i_snake_failure, i_snake_success,
    output o_snake_tick, o_state, o_running, o_period, o_failure, o_success,
           o_timeout
  );
endinterface

// File: rtl/game_sequencer.sv
// Per-tick scheduler for the snake game: counts frames, waits for the apple,
// pulses the snake tick and waits for the snake to finish. Also owns pause,
// game speed, sticky outcome flags and a watchdog on the tick handshake.
module game_sequencer #(
  parameter int FRAMES_INIT  = 8,
  parameter int FRAMES_MIN   = 2,
  parameter int FRAMES_MAX   = 15,
  parameter int DONE_TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst,
  game_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FRAME = 3'd1,
    WAIT_APPLE = 3'd2,
    TICK       = 3'd3,
    WAIT_DONE  = 3'd4,
    PAUSED     = 3'd5,
    FAILED     = 3'd6,
    WON        = 3'd7
  } state_t;

  localparam logic [3:0] PERIOD_INIT = 4'(FRAMES_INIT);
  localparam logic [3:0] PERIOD_MIN  = 4'(FRAMES_MIN);
  localparam logic [3:0] PERIOD_MAX  = 4'(FRAMES_MAX);
  // Watchdog value seen on the last allowed cycle in WAIT_DONE.
  localparam logic [7:0] WD_LAST     = 8'(DONE_TIMEOUT - 1);

  state_t     state, state_next;
  logic [3:0] frame_cnt, frame_cnt_next;
  logic [7:0] watchdog, watchdog_next;
  logic [3:0] period, period_next;
  logic       failure, failure_next;
  logic       success, success_next;
  logic       timeout, timeout_next;
  logic       snake_tick;
  logic       frame_due;
  logic       live;

  // The period may shrink below the current count, so the compare is >=.
  assign frame_due = (frame_cnt >= (period - 4'd1));
  // States in which snake collision/board-full outcomes are accepted.
  assign live = (state inside {WAIT_FRAME, WAIT_APPLE, TICK, WAIT_DONE, PAUSED});

  // Next-state, counters, speed and sticky flags; restart overrides everything.
  always_comb begin
    state_next     = state;
    frame_cnt_next = frame_cnt;
    watchdog_next  = watchdog;
    period_next    = period;
    failure_next   = failure;
    success_next   = success;
    timeout_next   = timeout;

    if (bus.i_speed_up && !bus.i_speed_down) begin
      if (period > PERIOD_MIN) period_next = period - 4'd1;
    end else if (bus.i_speed_down && !bus.i_speed_up) begin
      if (period < PERIOD_MAX) period_next = period + 4'd1;
    end

    if (bus.i_restart) begin
      state_next     = IDLE;
      frame_cnt_next = 4'd0;
      watchdog_next  = 8'd0;
      period_next    = PERIOD_INIT;
      failure_next   = 1'b0;
      success_next   = 1'b0;
      timeout_next   = 1'b0;
    end else if (live && bus.i_snake_failure) begin
      state_next   = FAILED;
      failure_next = 1'b1;
    end else if (live && bus.i_snake_success) begin
      state_next   = WON;
      success_next = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            state_next     = WAIT_FRAME;
            frame_cnt_next = 4'd0;
          end
        end
        WAIT_FRAME: begin
          if (bus.i_pause) begin
            state_next = PAUSED;
          end else if (bus.i_vsync) begin
            if (frame_due) state_next = WAIT_APPLE;
            else           frame_cnt_next = frame_cnt + 4'd1;
          end
        end
        PAUSED: begin
          if (!bus.i_pause) state_next = WAIT_FRAME;
        end
        WAIT_APPLE: begin
          if (bus.i_apple_ready) state_next = TICK;
        end
        TICK: begin
          state_next    = WAIT_DONE;
          watchdog_next = 8'd0;
        end
        WAIT_DONE: begin
          if (bus.i_tick_done) begin
            state_next     = WAIT_FRAME;
            frame_cnt_next = 4'd0;
          end else if (watchdog == WD_LAST) begin
            state_next     = WAIT_FRAME;
            frame_cnt_next = 4'd0;
            timeout_next   = 1'b1;
          end else begin
            watchdog_next = watchdog + 8'd1;
          end
        end
        FAILED, WON: begin
          state_next = state;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; the tick output is registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      frame_cnt  <= 4'd0;
      watchdog   <= 8'd0;
      period     <= PERIOD_INIT;
      failure    <= 1'b0;
      success    <= 1'b0;
      timeout    <= 1'b0;
      snake_tick <= 1'b0;
    end else begin
      state      <= state_next;
      frame_cnt  <= frame_cnt_next;
      watchdog   <= watchdog_next;
      period     <= period_next;
      failure    <= failure_next;
      success    <= success_next;
      timeout    <= timeout_next;
      snake_tick <= (state_next == TICK);
    end
  end

  assign bus.o_state      = state;
  assign bus.o_snake_tick = snake_tick;
  assign bus.o_running    = (state inside {WAIT_FRAME, WAIT_APPLE, TICK, WAIT_DONE});
  assign bus.o_period     = period;
  assign bus.o_failure    = failure;
  assign bus.o_success    = success;
  assign bus.o_timeout    = timeout;

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized bench for game_sequencer: stimulus tasks predict each snake
// tick from frame/period arithmetic and queue its cycle; a monitor pops
// and compares whenever the DUT raises o_snake_tick.
module tb_game_sequencer;
  localparam int FRAMES_INIT  = 8;
  localparam int FRAMES_MIN   = 2;
  localparam int FRAMES_MAX   = 15;
  localparam int DONE_TIMEOUT = 255;

  localparam int ST_IDLE = 0, ST_FRAME = 1, ST_APPLE = 2, ST_TICK = 3;
  localparam int ST_DONE = 4, ST_PAUSED = 5, ST_FAILED = 6, ST_WON = 7;

  logic clk = 1'b0;
  logic rst;

  game_sequencer_if bus();

  game_sequencer #(
    .FRAMES_INIT (FRAMES_INIT),
    .FRAMES_MIN  (FRAMES_MIN),
    .FRAMES_MAX  (FRAMES_MAX),
    .DONE_TIMEOUT(DONE_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_q[$];
  int   exp_cyc;
  int   model_period;
  bit   model_timeout;
  bit   speed_rand;
  logic pause_lvl, apple_lvl, start_lvl;

  // Edge counter shared by the stimulus and the monitor.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Scoreboard monitor: each tick pulse must match the next predicted cycle.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.o_snake_tick === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_tick: got tick at cycle %0d expected none", cyc);
      end else begin
        exp_cyc = exp_q.pop_front();
        if (exp_cyc != cyc) begin
          errors++;
          $display("[TB] FAIL tick_cycle: got %0d expected %0d", cyc, exp_cyc);
        end
      end
      checkOutput("tick_state", bus.o_state, ST_TICK);
    end
  end

  // One clock of stimulus; the speed model tracks every accepted pulse.
  task automatic applyStimulus(input logic vs, input logic up, input logic dn,
                               input logic done, input logic fail,
                               input logic succ, input logic restart);
    bus.i_vsync         = vs;
    bus.i_speed_up      = up;
    bus.i_speed_down    = dn;
    bus.i_tick_done     = done;
    bus.i_snake_failure = fail;
    bus.i_snake_success = succ;
    bus.i_restart       = restart;
    bus.i_pause         = pause_lvl;
    bus.i_apple_ready   = apple_lvl;
    bus.i_start         = start_lvl;
    if (restart) begin
      model_period  = FRAMES_INIT;
      model_timeout = 0;
    end else if (up && !dn) begin
      model_period = (model_period > FRAMES_MIN) ? model_period - 1 : FRAMES_MIN;
    end else if (dn && !up) begin
      model_period = (model_period < FRAMES_MAX) ? model_period + 1 : FRAMES_MAX;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic vs, input logic done);
    logic up, dn;
    up = speed_rand && ($urandom_range(0, 7) == 0);
    dn = speed_rand && ($urandom_range(0, 7) == 0);
    applyStimulus(vs, up, dn, done, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic restartGame();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("restart_state", bus.o_state, ST_IDLE);
    checkOutput("restart_tick", bus.o_snake_tick, 0);
    checkOutput("restart_period", bus.o_period, FRAMES_INIT);
    checkOutput("restart_failure", bus.o_failure, 0);
    checkOutput("restart_success", bus.o_success, 0);
    checkOutput("restart_timeout", bus.o_timeout, 0);
  endtask

  task automatic enterRun();
    start_lvl = 1'b1;
    step(1'b0, 1'b0);
    checkOutput("start_state", bus.o_state, ST_FRAME);
    checkOutput("start_running", bus.o_running, 1);
  endtask

  task automatic doPause(input int vsyncs);
    pause_lvl = 1'b1;
    for (int i = 0; i < 2 * vsyncs; i++) begin
      step(logic'(i % 2), 1'b0);
      checkOutput("paused_state", bus.o_state, ST_PAUSED);
    end
    pause_lvl = 1'b0;
    step(1'b1, 1'b0);
    checkOutput("resume_state", bus.o_state, ST_FRAME);
  endtask

  // Frame wait: returns the edge at which the qualifying vsync was taken.
  task automatic runFrames(input int pause_at, output int qual_edge);
    int seen, gap;
    bit fired;
    seen = 0;
    fired = 0;
    qual_edge = 0;
    while (!fired) begin
      gap = $urandom_range(0, 3);
      repeat (gap) step(1'b0, 1'b0);
      if (seen == pause_at) begin
        doPause(20);
        pause_at = -2;
      end else if (pause_at == -1 && $urandom_range(0, 9) == 0) begin
        doPause($urandom_range(1, 4));
      end
      if (seen >= model_period - 1) fired = 1;
      else seen++;
      step(1'b1, 1'b0);
      if (fired) qual_edge = cyc;
      else checkOutput("frame_state", bus.o_state, ST_FRAME);
    end
  endtask

  // One full tick sequence. mode 0: done returned; 1: watchdog expiry;
  // 2: stop in WAIT_DONE; 3: stop in TICK.
  task automatic runSequence(input int apple_delay, input int mode, input int pause_at);
    int k, t, e;
    apple_lvl = (apple_delay == 0);
    runFrames(pause_at, k);
    t = k + 1 + apple_delay;
    exp_q.push_back(t);
    apple_lvl = 1'b0;
    for (int i = 0; i < apple_delay; i++) begin
      pause_lvl = ($urandom_range(0, 1) == 1);
      step(($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
      checkOutput("apple_wait_state", bus.o_state, ST_APPLE);
    end
    pause_lvl = 1'b0;
    apple_lvl = 1'b1;
    step(1'b0, 1'b0);
    checkOutput("tick_running", bus.o_running, 1);
    if (mode == 3) return;
    step(1'b0, ($urandom_range(0, 2) == 0));
    checkOutput("wait_done_state", bus.o_state, ST_DONE);
    if (mode == 2) return;
    if (mode == 0) begin
      e = $urandom_range(0, 5);
      repeat (e) step(($urandom_range(0, 1) == 1), 1'b0);
      step(1'b0, 1'b1);
      checkOutput("after_done_state", bus.o_state, ST_FRAME);
    end else begin
      repeat (DONE_TIMEOUT - 1) step(($urandom_range(0, 3) == 0), 1'b0);
      checkOutput("watchdog_pending_state", bus.o_state, ST_DONE);
      checkOutput("watchdog_pending_flag", bus.o_timeout, model_timeout);
      step(1'b0, 1'b0);
      model_timeout = 1;
      checkOutput("watchdog_state", bus.o_state, ST_FRAME);
    end
    checkOutput("seq_timeout", bus.o_timeout, model_timeout);
    checkOutput("seq_period", bus.o_period, model_period);
  endtask

  initial begin
    rst = 1'b1;
    pause_lvl = 1'b0;
    apple_lvl = 1'b0;
    start_lvl = 1'b0;
    speed_rand = 0;
    model_period = FRAMES_INIT;
    model_timeout = 0;
    bus.i_restart = 1'b0;
    bus.i_start = 1'b0;
    bus.i_pause = 1'b0;
    bus.i_vsync = 1'b0;
    bus.i_speed_up = 1'b0;
    bus.i_speed_down = 1'b0;
    bus.i_apple_ready = 1'b0;
    bus.i_tick_done = 1'b0;
    bus.i_snake_failure = 1'b0;
    bus.i_snake_success = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", bus.o_state, ST_IDLE);
    checkOutput("reset_tick", bus.o_snake_tick, 0);
    checkOutput("reset_running", bus.o_running, 0);
    checkOutput("reset_period", bus.o_period, FRAMES_INIT);
    checkOutput("reset_failure", bus.o_failure, 0);
    checkOutput("reset_success", bus.o_success, 0);
    checkOutput("reset_timeout", bus.o_timeout, 0);
    rst = 1'b0;

    $display("[TB] speed saturation");
    repeat (8) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("speed_min", bus.o_period, model_period);
    checkOutput("speed_min_abs", bus.o_period, FRAMES_MIN);
    repeat (18) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("speed_max", bus.o_period, FRAMES_MAX);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("speed_both", bus.o_period, FRAMES_MAX);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("speed_down_from_max", bus.o_period, FRAMES_MAX - 1);
    restartGame();

    $display("[TB] directed tick sequences");
    enterRun();
    runSequence(0, 0, -2);
    runSequence(0, 0, 3);
    runSequence(100, 0, -2);
    runSequence(0, 1, -2);
    runSequence(0, 0, -2);

    $display("[TB] randomized tick sequences");
    speed_rand = 1;
    for (int n = 0; n < 30; n++)
      runSequence($urandom_range(0, 4), ($urandom_range(0, 9) == 0) ? 1 : 0, -1);

    $display("[TB] restart during tick");
    runSequence(1, 3, -1);
    restartGame();
    checkOutput("restart_running", bus.o_running, 0);
    speed_rand = 0;

    $display("[TB] failure and success together");
    enterRun();
    runSequence(0, 2, -2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("failed_state", bus.o_state, ST_FAILED);
    checkOutput("failed_flag", bus.o_failure, 1);
    checkOutput("failed_success", bus.o_success, 0);
    checkOutput("failed_running", bus.o_running, 0);
    for (int i = 0; i < 24; i++) step(logic'(i % 2), logic'(i % 3 == 0));
    checkOutput("failed_terminal", bus.o_state, ST_FAILED);
    restartGame();

    $display("[TB] success then late failure");
    enterRun();
    repeat (3) step(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("won_state", bus.o_state, ST_WON);
    checkOutput("won_flag", bus.o_success, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("won_terminal", bus.o_state, ST_WON);
    checkOutput("won_no_failure", bus.o_failure, 0);
    restartGame();

    repeat (3) step(1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_ticks: got %0d unmatched expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
